tf_gen_responder: RTL and testbench
===================================

TF_GEN_RESPONDER -- requirements
Module: tf_gen_responder

Interface
REQ-001 SHALL have parameter DW, default 32: data and modulus width in bits.
REQ-002 SHALL have parameter DEPTH_N, default 4: number of NTT stages held, indexed 0..DEPTH_N-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port TF_init_base, input, 1: reset every stage's current twiddle to 1.
REQ-006 SHALL have port TF_init_const, input, 1: load every stage's step constant from step_const_in.
REQ-007 SHALL have port TF_ren, input, 1: read request for stage it_depth_cnt.
REQ-008 SHALL have port TF_wen, input, 1: advance request, cur[it_depth_cnt] <= cur*step mod modulus.
REQ-009 SHALL have port it_depth_cnt, input, `D_width: stage index for read and advance.
REQ-010 SHALL have port step_const_in, input, DEPTH_N*DW: stage s constant in bits [s*DW +: DW].
REQ-011 SHALL have port modulus, input, DW: prime modulus, held stable while tf_busy=1.
REQ-012 SHALL have port tf_out, output, DW: registered twiddle read data.
REQ-013 SHALL have port tf_valid, output, 1: tf_out is valid this cycle.
REQ-014 SHALL have port tf_busy, output, 1: a modular multiply is in progress.
REQ-015 SHALL have port tf_err, output, 1: sticky protocol-error flag.

Function
REQ-016 Read latency SHALL be 1 cycle: TF_ren at cycle t -> tf_valid=1 and tf_out=cur[it_depth_cnt] at t+1; tf_valid=0 otherwise.
REQ-017 A read with it_depth_cnt >= DEPTH_N SHALL return tf_out=0 with tf_valid=1.
REQ-018 Update FSM states SHALL be IDLE -> MUL -> DONE -> IDLE; tf_busy=1 in MUL and DONE only.
REQ-019 In IDLE, TF_wen with valid index SHALL latch the index, a=cur[idx], b=step[idx], and acc=0, then enter MUL.
REQ-020 MUL SHALL run exactly DW cycles of MSB-first interleaved modular multiply: acc <= (2*acc + b_bit*a) mod modulus, with each intermediate reduced by conditional subtraction and computed DW+2 bits wide.
REQ-021 DONE SHALL last 1 cycle and write acc into cur[idx]; TF_wen at cycle t SHALL therefore give tf_busy high for t+1..t+DW+1 and the new value readable from TF_ren at t+DW+2.
REQ-022 Operands a, b SHALL be < modulus; results are then < modulus. Otherwise the result is undefined.
REQ-023 TF_wen while tf_busy=1, or with it_depth_cnt >= DEPTH_N, SHALL be ignored and SHALL set tf_err=1 until reset.
REQ-024 Same-cycle TF_ren and TF_wen SHALL return the pre-update value.
REQ-025 Precedence SHALL be TF_init_base > TF_init_const > TF_wen. TF_init_base during MUL/DONE SHALL abort the multiply: FSM to IDLE, no writeback, all cur=1, tf_busy=0 next cycle.
REQ-026 TF_init_const during MUL/DONE SHALL update all step registers; the in-flight multiply SHALL keep its latched b.
REQ-027 TF_init_base and TF_init_const asserted together SHALL both take effect in the same cycle.

Reset
REQ-028 With rst=0 at a clock edge: tf_out=0, tf_valid=0, tf_busy=0, tf_err=0, FSM=IDLE, all cur=1, all step=0.
REQ-029 Reset mid-multiply SHALL discard the operation with no writeback.

Configuration
REQ-030 Macro TF_READ_FWD_EN: when defined, TF_ren hitting the DONE-state index in the DONE cycle SHALL return the new product at t+1. When undefined, it SHALL return the old value (new value one cycle later).

Verification
REQ-031 Reset: rst=0 for 2 cycles -> tf_out=0, tf_valid=0, tf_busy=0, tf_err=0.
REQ-032 TF_init_base, then TF_ren at depth 0 -> next cycle tf_valid=1, tf_out=1.
REQ-033 modulus=17, step1=3, three sequential TF_wen at depth 1, each waiting for tf_busy=0 -> reads give 3, 9, 10; tf_busy high exactly DW+1 cycles each.
REQ-034 TF_wen at depth 1 while tf_busy=1 -> tf_err=1; the completed value equals the single in-flight result.
REQ-035 TF_init_base 5 cycles into MUL -> tf_busy=0 next cycle; all stages read 1.
REQ-036 TF_ren at depth DEPTH_N -> tf_out=0, tf_valid=1; TF_wen at depth DEPTH_N -> tf_err=1 and no cur change.

Source files
------------

// File: rtl/tf_gen_responder.sv
`default_nettype none
// ============================================================================
// Module   : tf_gen_responder
// Purpose  : Per-stage NTT twiddle-factor generator. Each of DEPTH_N stages
//            holds a current twiddle (cur) and a step constant (step). An
//            advance request replaces cur[idx] with cur[idx]*step[idx] mod
//            modulus. It uses a bit-serial, MSB-first interleaved modular
//            multiplier, which takes DW cycles plus one writeback cycle.
// Ports    : clk, rst (sync, active-low)
//            TF_init_base   - set every cur to 1
//            TF_init_const  - load every step from step_const_in
//            TF_ren         - read cur[it_depth_cnt], 1-cycle latency
//            TF_wen         - advance cur[it_depth_cnt]
//            it_depth_cnt   - stage index (`D_width bits)
//            step_const_in  - stage s constant at [s*DW +: DW]
//            modulus        - prime modulus, stable while tf_busy
//            tf_out/tf_valid- registered read data / valid strobe
//            tf_busy        - multiply or writeback in progress
//            tf_err         - sticky protocol error
// Macros   : TF_READ_FWD_EN - forward the product to a read of the stage
//                             being written back in the DONE cycle
//            D_width        - index width (defaults to $clog2(DEPTH_N)+1)
// Revision : 1.0 - initial release
// ============================================================================
`ifndef D_width
`define D_width ($clog2(DEPTH_N)+1)
`endif

module tf_gen_responder #(
  parameter int DW      = 32,
  parameter int DEPTH_N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TF_init_base,
  input  logic                  TF_init_const,
  input  logic                  TF_ren,
  input  logic                  TF_wen,
  input  logic [`D_width-1:0]   it_depth_cnt,
  input  logic [DEPTH_N*DW-1:0] step_const_in,
  input  logic [DW-1:0]         modulus,
  output logic [DW-1:0]         tf_out,
  output logic                  tf_valid,
  output logic                  tf_busy,
  output logic                  tf_err
);

  localparam int C_IW = `D_width;
  localparam int C_AW = (DEPTH_N > 1) ? $clog2(DEPTH_N) : 1;
  localparam int C_CW = $clog2(DW + 1);
  localparam logic [C_IW-1:0] C_DEPTH = C_IW'(DEPTH_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DW-1:0]     r_cur  [DEPTH_N];
  logic [DW-1:0]     r_step [DEPTH_N];
  logic [C_AW-1:0]   r_idx;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [DW-1:0]     r_acc;
  logic [C_CW-1:0]   r_cnt;
  logic [DW-1:0]     r_tf_out;
  logic              r_valid;
  logic              r_err;

  logic              w_idx_ok;
  logic [C_AW-1:0]   w_aidx;
  logic              w_start;
  logic              w_wb;
  logic              w_err_set;
  logic [DW-1:0]     w_rd_data;
  logic [DW+1:0]     w_mod_x;
  logic [DW+1:0]     w_dbl;
  logic [DW+1:0]     w_dbl_red;
  logic [DW+1:0]     w_sum;
  logic [DW+1:0]     w_sum_red;
  logic [1:0]        w_unused_hi;

  assign w_idx_ok = (it_depth_cnt < C_DEPTH);
  assign w_aidx   = it_depth_cnt[C_AW-1:0];

  // One MSB-first step: acc = (2*acc + bit*a) mod m. Both partial results
  // stay below 2m, so a single conditional subtraction reduces each, and
  // DW+2 bits hold them without overflow.
  assign w_mod_x     = {2'b00, modulus};
  assign w_dbl       = {1'b0, r_acc, 1'b0};
  assign w_dbl_red   = (w_dbl >= w_mod_x) ? (w_dbl - w_mod_x) : w_dbl;
  assign w_sum       = w_dbl_red + (r_b[DW-1] ? {2'b00, r_a} : {(DW+2){1'b0}});
  assign w_sum_red   = (w_sum >= w_mod_x) ? (w_sum - w_mod_x) : w_sum;
  assign w_unused_hi = w_sum_red[DW+1:DW];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (TF_init_base) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (TF_wen && !TF_init_const && w_idx_ok) begin
            w_state_nxt = S_MUL;
            w_start     = 1'b1;
          end
        end
        S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_wb      = (r_state == S_DONE) && !TF_init_base;
    // An advance request that is outranked by an init is not an error;
    // one that is actually considered but cannot start is.
    w_err_set = TF_wen && !TF_init_base && !TF_init_const &&
                ((r_state != S_IDLE) || !w_idx_ok);
  end

  // Read mux: out-of-range stages read as zero.
  always_comb begin
    w_rd_data = '0;
    if (w_idx_ok) begin
`ifdef TF_READ_FWD_EN
      if (w_wb && (r_idx == w_aidx)) w_rd_data = r_acc;
      else                           w_rd_data = r_cur[w_aidx];
`else
      w_rd_data = r_cur[w_aidx];
`endif
    end
  end

  // Datapath and storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH_N; s++) begin
        r_cur[s]  <= DW'(1);
        r_step[s] <= '0;
      end
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tf_out <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (TF_init_base) begin
        for (int s = 0; s < DEPTH_N; s++) r_cur[s] <= DW'(1);
      end else if (w_wb) begin
        r_cur[r_idx] <= r_acc;
      end

      // The in-flight multiply holds its own copy of b, so reloading the
      // step table here never disturbs it.
      if (TF_init_const) begin
        for (int s = 0; s < DEPTH_N; s++) r_step[s] <= step_const_in[s*DW +: DW];
      end

      if (w_start) begin
        r_idx <= w_aidx;
        r_a   <= r_cur[w_aidx];
        r_b   <= r_step[w_aidx];
        r_acc <= '0;
        r_cnt <= C_CW'(DW - 1);
      end else if (r_state == S_MUL) begin
        r_acc <= w_sum_red[DW-1:0];
        r_b   <= {r_b[DW-2:0], 1'b0};
        r_cnt <= r_cnt - C_CW'(1);
      end

      if (w_err_set) r_err <= 1'b1;

      r_valid <= TF_ren;
      if (TF_ren) r_tf_out <= w_rd_data;
    end
  end

  assign tf_out   = r_tf_out;
  assign tf_valid = r_valid;
  assign tf_busy  = (r_state != S_IDLE);
  assign tf_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tf_gen_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tf_gen_responder
// Purpose  : Self-checking bench for tf_gen_responder. A behavioural model
//            of cur/step produces expected read data, which is queued when a
//            read is driven and compared when tf_valid is returned.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tf_gen_responder;

  localparam int DW      = 32;
  localparam int DEPTH_N = 4;
  localparam int IW      = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  TF_init_base, TF_init_const, TF_ren, TF_wen;
  logic [IW-1:0]         it_depth_cnt;
  logic [DEPTH_N*DW-1:0] step_const_in;
  logic [DW-1:0]         modulus;
  logic [DW-1:0]         tf_out;
  logic                  tf_valid, tf_busy, tf_err;

  tf_gen_responder #(.DW(DW), .DEPTH_N(DEPTH_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .TF_init_base  (TF_init_base),
    .TF_init_const (TF_init_const),
    .TF_ren        (TF_ren),
    .TF_wen        (TF_wen),
    .it_depth_cnt  (it_depth_cnt),
    .step_const_in (step_const_in),
    .modulus       (modulus),
    .tf_out        (tf_out),
    .tf_valid      (tf_valid),
    .tf_busy       (tf_busy),
    .tf_err        (tf_err)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] sb_val[$];
  string         sb_tag[$];
  logic [DW-1:0] m_cur  [DEPTH_N];
  logic [DW-1:0] m_step [DEPTH_N];

  task automatic chk_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mulmod(logic [DW-1:0] a, logic [DW-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    p = p % {32'b0, modulus};
    return p[DW-1:0];
  endfunction

  // Advance one clock; compare read responses against the scoreboard.
  task automatic tick();
    bit exp_v;
    exp_v = TF_ren && rst;
    @(posedge clk);
    #1;
    chk_eq("valid", tf_valid, exp_v);
    if (exp_v) begin
      chk_eq("sb_depth", sb_val.size(), (sb_val.size() == 0) ? 1 : sb_val.size());
      if (sb_val.size() > 0) chk_eq(sb_tag.pop_front(), tf_out, sb_val.pop_front());
    end
  endtask

  task automatic push_exp(logic [DW-1:0] v, string tag);
    sb_val.push_back(v);
    sb_tag.push_back(tag);
  endtask

  task automatic rd(int idx, string tag);
    push_exp((idx < DEPTH_N) ? m_cur[idx] : '0, tag);
    TF_ren = 1'b1; it_depth_cnt = IW'(idx);
    tick();
    TF_ren = 1'b0;
  endtask

  task automatic rd_all(string tag);
    for (int s = 0; s < DEPTH_N; s++) rd(s, tag);
  endtask

  task automatic load_const();
    for (int s = 0; s < DEPTH_N; s++) step_const_in[s*DW +: DW] = m_step[s];
    TF_init_const = 1'b1;
    tick();
    TF_init_const = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    chk_eq("rst_out",   tf_out,   0);
    chk_eq("rst_valid", tf_valid, 0);
    chk_eq("rst_busy",  tf_busy,  0);
    chk_eq("rst_err",   tf_err,   0);
    rst = 1'b1;
    for (int s = 0; s < DEPTH_N; s++) begin m_cur[s] = 1; m_step[s] = 0; end
  endtask

  // Advance a stage and measure how long tf_busy stays high.
  task automatic upd(int idx, bit with_rd, string tag);
    int cnt;
    TF_wen = 1'b1; it_depth_cnt = IW'(idx);
    if (with_rd) begin TF_ren = 1'b1; push_exp(m_cur[idx], {tag, "_same_cyc"}); end
    tick();
    TF_wen = 1'b0; TF_ren = 1'b0;
    m_cur[idx] = mulmod(m_cur[idx], m_step[idx]);
    cnt = 0;
    while (tf_busy && cnt < 200) begin cnt++; tick(); end
    chk_eq({tag, "_busy_len"}, cnt, DW + 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; TF_init_base = 0; TF_init_const = 0; TF_ren = 0; TF_wen = 0;
    it_depth_cnt = '0; step_const_in = '0; modulus = 32'd17;

    do_reset();

    // Init base then read every stage
    TF_init_base = 1'b1; tick(); TF_init_base = 1'b0;
    rd_all("base_rd");

    // Sequential advances mod 17, step 3: 3, 9, 10
    m_step[0] = 2; m_step[1] = 3; m_step[2] = 5; m_step[3] = 16;
    load_const();
    for (int k = 0; k < 3; k++) begin
      upd(1, 1'b0, "seq");
      rd(1, "seq_rd");
    end
    chk_eq("seq_final_model", m_cur[1], 10);
    // Same-cycle read sees the old value, then 30 mod 17 = 13
    upd(1, 1'b1, "rw");
    rd(1, "rw_rd");
    chk_eq("err_clean", tf_err, 0);

    // Read in the DONE cycle on stage 3
    TF_wen = 1'b1; it_depth_cnt = 3'd3; tick(); TF_wen = 1'b0;
    for (int k = 0; k < DW; k++) tick();
    chk_eq("done_busy", tf_busy, 1);
`ifdef TF_READ_FWD_EN
    push_exp(mulmod(m_cur[3], m_step[3]), "done_rd");
`else
    push_exp(m_cur[3], "done_rd");
`endif
    TF_ren = 1'b1; it_depth_cnt = 3'd3; tick(); TF_ren = 1'b0;
    m_cur[3] = mulmod(m_cur[3], m_step[3]);
    chk_eq("done_busy_clr", tf_busy, 0);
    rd(3, "done_after_rd");

    // Step reload during multiply keeps latched b
    TF_wen = 1'b1; it_depth_cnt = 3'd0; tick(); TF_wen = 1'b0;
    tick(); tick();
    m_step[0] = 7;
    load_const();
    m_cur[0] = mulmod(m_cur[0], 2);
    cnt = 0;
    while (tf_busy && cnt < 200) begin cnt++; tick(); end
    chk_eq("cst_busy_end", tf_busy, 0);
    rd(0, "cst_inflight_rd");
    upd(0, 1'b0, "cst_new");
    rd(0, "cst_new_rd");

    // Overlapping advance: error flagged, single result kept
    TF_wen = 1'b1; it_depth_cnt = 3'd2; tick();
    tick(); TF_wen = 1'b0;
    m_cur[2] = mulmod(m_cur[2], m_step[2]);
    chk_eq("ovl_err", tf_err, 1);
    cnt = 0;
    while (tf_busy && cnt < 200) begin cnt++; tick(); end
    chk_eq("ovl_busy_len", cnt, DW);
    rd(2, "ovl_rd");

    // Abort 5 cycles into MUL
    TF_wen = 1'b1; it_depth_cnt = 3'd1; tick(); TF_wen = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_eq("abort_pre_busy", tf_busy, 1);
    TF_init_base = 1'b1; tick(); TF_init_base = 1'b0;
    for (int s = 0; s < DEPTH_N; s++) m_cur[s] = 1;
    chk_eq("abort_busy", tf_busy, 0);
    for (int k = 0; k < DW + 4; k++) tick();
    rd_all("abort_rd");

    // Out-of-range index
    do_reset();
    rd(DEPTH_N, "oor_rd");
    rd(7, "oor7_rd");
    TF_wen = 1'b1; it_depth_cnt = IW'(DEPTH_N); tick(); TF_wen = 1'b0;
    chk_eq("oor_err", tf_err, 1);
    chk_eq("oor_busy", tf_busy, 0);
    rd_all("oor_nochg");

    // Reset mid-multiply discards the operation
    do_reset();
    m_step[0] = 5; load_const();
    TF_wen = 1'b1; it_depth_cnt = 3'd0; tick(); TF_wen = 1'b0;
    tick(); tick();
    do_reset();
    m_step[0] = 5; load_const();
    rd(0, "rstmid_rd");

    // Wide modulus exercises the full DW+2 intermediate width
    modulus = 32'hFFFF_FFFB;
    m_step[0] = 32'hFFFF_FFFA; m_step[1] = 32'h8000_0001;
    m_step[2] = $urandom_range(32'h7FFF_FFFF, 2); m_step[3] = 32'hDEAD_BEEF;
    load_const();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < DEPTH_N; s++) begin
        upd(s, 1'b0, "wide");
        rd(s, "wide_rd");
      end
    end
    chk_eq("wide_err", tf_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
